// File: rtl/fifo_put_arbiter_pkg.sv
// fifo_put_arbiter_pkg: shared state encoding and put counter width for the FIFO put arbiter
package fifo_put_arbiter_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {INIT, ARB, STALL} state_t;
endpackage

// File: rtl/fifo_put_arbiter_rr_pick.sv
// fifo_put_arbiter_rr_pick: combinational round-robin selector, search starts one past ptr
//   req   : candidate request vector
//   ptr   : index of the last winner
//   win   : one-hot winner
//   idx   : winner index
//   valid : any candidate present
module fifo_put_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++)
      if (!valid && req[IW'((int'(ptr) + k) % N_REQ)]) begin
        valid = 1'b1;
        idx = IW'((int'(ptr) + k) % N_REQ);
      end
    win = N_REQ'(valid) << idx;
  end
endmodule

// File: rtl/fifo_put_arbiter.sv
// fifo_put_arbiter: round-robin arbiter funnelling N_REQ requesters into one FIFO ring put port
//   clk_put, reset : clock, asynchronous active-high reset
//   req, data_in   : per-requester request and word (word i at [i*N_BITS +: N_BITS])
//   full, hold     : ring back-pressure, either one blocks puts
//   init_put       : one-cycle token-initialisation pulse after reset
//   en_put, data_put, grant : registered put strobe, word and one-hot acknowledge
//   put_count      : accepted puts since reset, wrapping
module fifo_put_arbiter
  import fifo_put_arbiter_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int N_REQ = 4
) (
  input  logic                    clk_put,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*N_BITS-1:0] data_in,
  input  logic                    full,
  input  logic                    hold,
  output logic                    init_put,
  output logic                    en_put,
  output logic [N_BITS-1:0]       data_put,
  output logic [N_REQ-1:0]        grant,
  output logic [CNT_W-1:0]        put_count
);
  localparam int IW = $clog2(N_REQ);
  state_t state, state_nxt;
  logic [IW-1:0] last, idx;
  logic [N_REQ-1:0] win;
  logic valid, put;
  // the requester granted this cycle sits out one round so it can drop or renew its request
  fifo_put_arbiter_rr_pick #(.N_REQ(N_REQ)) rr_pick (
    .req(req & ~grant),
    .ptr(last),
    .win(win),
    .idx(idx),
    .valid(valid)
  );
  always_comb begin
    state_nxt = state == INIT ? ARB : (full | hold) ? STALL : ARB;
    put = state == ARB && !(full | hold) && valid;
  end
  always_ff @(posedge clk_put or posedge reset)
    if (reset) begin
      state <= INIT;
      init_put <= 1'b0;
      en_put <= 1'b0;
      grant <= '0;
      data_put <= '0;
      put_count <= '0;
      last <= IW'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      init_put <= state == INIT;
      en_put <= put;
      grant <= put ? win : '0;
      if (put) begin
        data_put <= data_in[idx*N_BITS +: N_BITS];
        last <= idx;
        put_count <= put_count + 1'b1;
      end
    end
endmodule
